// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin sharing of the single-port data memory between
// the load/store unit (port 0) and the debug/DMA loader (port 1). Turns
// sized byte-addressed requests into word index, byte mask and replicated
// write data, and returns formatted read data one cycle after the grant.
module dmem_arbiter #(
  parameter int unsigned MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,

  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } size_e;

  // Everything needed to format the response in the cycle after the grant.
  typedef struct packed {
    logic       valid;
    logic       port;
    logic       we;
    logic       err;
    logic [1:0] off;
    size_e      size;
    logic       uns;
  } rsp_t;

  logic        last_gnt;
  logic        any_gnt;
  logic        sel_we;
  logic [31:0] sel_addr;
  size_e       sel_size;
  logic        sel_uns;
  logic [31:0] sel_wdata;
  logic        sel_err;
  rsp_t        rsp;
  logic        rsp_live;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Round-robin grant: a lone requester wins, a tie goes to the port not
  // granted last; nothing is granted while reset is held.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (!rst) begin
      p0_gnt = p0_req && (!p1_req || last_gnt);
      p1_gnt = p1_req && (!p0_req || !last_gnt);
    end
  end

  assign any_gnt = p0_gnt | p1_gnt;

  // Mux the granted request's fields and classify it.
  always_comb begin
    sel_we    = p1_gnt ? p1_we       : p0_we;
    sel_addr  = p1_gnt ? p1_addr     : p0_addr;
    sel_size  = size_e'(p1_gnt ? p1_size : p0_size);
    sel_uns   = p1_gnt ? p1_unsigned : p0_unsigned;
    sel_wdata = p1_gnt ? p1_wdata    : p0_wdata;
    sel_err   = ({2'b00, sel_addr[31:2]} >= 32'(MEM_WORDS));
    case (sel_size)
      SZ_HALF: if (sel_addr[0])          sel_err = 1'b1;
      SZ_WORD: if (sel_addr[1:0] != 2'b00) sel_err = 1'b1;
      SZ_ILL:  sel_err = 1'b1;
      default: ;
    endcase
  end

  // Drive the memory port; only a granted, clean store writes.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wmask = '0;
    mem_we    = 1'b0;
    if (any_gnt) begin
      mem_addr = {2'b00, sel_addr[31:2]};
      case (sel_size)
        SZ_BYTE: mem_wdata = {4{sel_wdata[7:0]}};
        SZ_HALF: mem_wdata = {2{sel_wdata[15:0]}};
        default: mem_wdata = sel_wdata;
      endcase
      if (sel_we && !sel_err) begin
        mem_we = 1'b1;
        case (sel_size)
          SZ_BYTE: mem_wmask = 4'b0001 << sel_addr[1:0];
          SZ_HALF: mem_wmask = 4'b0011 << sel_addr[1:0];
          default: mem_wmask = 4'b1111;
        endcase
      end
    end
  end

  // Round-robin pointer and response pipeline register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      last_gnt <= 1'b1;
      rsp      <= '0;
    end else begin
      if (any_gnt) begin
        last_gnt <= p1_gnt;
        rsp      <= '{valid: 1'b1, port: p1_gnt, we: sel_we, err: sel_err,
                      off: sel_addr[1:0], size: sel_size, uns: sel_uns};
      end else begin
        rsp <= '0;
      end
    end
  end

  // Extract and extend load data from the memory's registered read word.
  always_comb begin
    ld_byte = mem_rdata[{rsp.off, 3'b000} +: 8];
    ld_half = mem_rdata[{rsp.off[1], 4'b0000} +: 16];
    case (rsp.size)
      SZ_BYTE: ld_data = {{24{~rsp.uns & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~rsp.uns & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
    if (rsp.we || rsp.err) ld_data = '0;
  end

  // A response left over from before reset is dropped while reset is high.
  assign rsp_live  = rsp.valid & ~rst;
  assign p0_rvalid = rsp_live & ~rsp.port;
  assign p1_rvalid = rsp_live &  rsp.port;
  assign p0_rdata  = p0_rvalid ? ld_data : '0;
  assign p1_rdata  = p1_rvalid ? ld_data : '0;
  assign p0_err    = p0_rvalid & rsp.err;
  assign p1_err    = p1_rvalid & rsp.err;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven requests with a response scoreboard, plus
// hand-written arbitration and reset sequences, against a 1024-word memory.
module tb_dmem_arbiter;

  localparam int unsigned MEM_WORDS = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0, p0_unsigned = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic [1:0]  p0_size = '0;
  logic        p1_req = 1'b0, p1_we = 1'b0, p1_unsigned = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic [1:0]  p1_size = '0;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_we;

  dmem_arbiter #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_size(p0_size),
    .p0_unsigned(p0_unsigned), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
    .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_size(p1_size),
    .p1_unsigned(p1_unsigned), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
    .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Data memory with a one-cycle registered read.
  logic [31:0] mem [0:MEM_WORDS-1];
  initial for (int i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we && mem_addr < MEM_WORDS)
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) mem[mem_addr[9:0]][8*b +: 8] <= mem_wdata[8*b +: 8];
    mem_rdata <= (mem_addr < MEM_WORDS) ? mem[mem_addr[9:0]] : 32'h0;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  typedef struct {
    bit          port;
    int          cycle;
    logic [31:0] rdata;
    bit          err;
  } exp_rsp_t;

  exp_rsp_t sb[$];

  task automatic push(input bit port, input logic [31:0] rdata, input bit err);
    exp_rsp_t e;
    e.port = port; e.cycle = cycle; e.rdata = rdata; e.err = err;
    sb.push_back(e);
  endtask

  // Response checker: each grant must produce exactly one response on its
  // own port in the following cycle.
  always @(negedge clk) begin
    exp_rsp_t e;
    if (sb.size() > 0 && sb[0].cycle + 1 == cycle) begin
      e = sb.pop_front();
      check("rsp_rvalid", e.port ? p1_rvalid : p0_rvalid, 1);
      check("rsp_rdata",  e.port ? p1_rdata  : p0_rdata,  e.rdata);
      check("rsp_err",    e.port ? p1_err    : p0_err,    e.err);
      check("rsp_other_rvalid", e.port ? p0_rvalid : p1_rvalid, 0);
    end else if (p0_rvalid || p1_rvalid) begin
      check("spurious_rvalid", {p0_rvalid, p1_rvalid}, 0);
    end
  end

  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    bit          uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    bit          exp_err;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
  } vec_t;

  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wdata);
    if (port == 1'b0) begin
      p0_req = req; p0_we = we; p0_addr = addr; p0_size = size; p0_unsigned = uns; p0_wdata = wdata;
    end else begin
      p1_req = req; p1_we = we; p1_addr = addr; p1_size = size; p1_unsigned = uns; p1_wdata = wdata;
    end
  endtask

  // Present one request (called just after a rising edge), wait a bounded
  // time for its grant, check the memory side and queue its response.
  task automatic issue(input vec_t v);
    bit got = 0;
    drive(v.port, 1, v.we, v.addr, v.size, v.uns, v.wdata);
    for (int k = 0; k < 16 && !got; k++) begin
      @(negedge clk);
      if ((v.port ? p1_gnt : p0_gnt) == 1'b1) begin
        got = 1;
        check("mem_addr",  mem_addr,  {2'b00, v.addr[31:2]});
        check("mem_we",    mem_we,    v.we && !v.exp_err);
        check("mem_wmask", mem_wmask, v.exp_mask);
        if (v.we && !v.exp_err) check("mem_wdata", mem_wdata, v.exp_wdata);
        push(v.port, v.exp_rdata, v.exp_err);
      end
      @(posedge clk); #1;
    end
    if (!got) check("gnt_timeout", 0, 1);
    drive(v.port, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t tbl[$];

  initial begin
    vec_t v;

    // Reset state with both ports requesting: no grants, no writes, no responses.
    drive(0, 1, 1, 32'h40, 2'b10, 0, 32'hCAFEF00D);
    drive(1, 1, 0, 32'h40, 2'b10, 0, 32'h0);
    repeat (2) begin
      @(negedge clk);
      check("rst_gnt", {p0_gnt, p1_gnt}, 0);
      check("rst_mem_we", mem_we, 0);
      check("rst_mem_wmask", mem_wmask, 0);
      check("rst_rvalid", {p0_rvalid, p1_rvalid}, 0);
      check("rst_err", {p0_err, p1_err}, 0);
      check("rst_rdata", p0_rdata | p1_rdata, 0);
    end
    @(posedge clk); #1 rst = 1'b0;

    // Continuous dual requests alternate starting with port 0.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("arb_gnt0", p0_gnt, (i % 2 == 0));
      check("arb_gnt1", p1_gnt, (i % 2 == 1));
      if (p0_gnt) push(0, 32'h0, 0);
      if (p1_gnt) push(1, 32'hCAFEF00D, 0);
      @(posedge clk); #1;
    end
    p0_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("solo_gnt1", p1_gnt, 1);
      check("solo_gnt0", p0_gnt, 0);
      if (p1_gnt) push(1, 32'hCAFEF00D, 0);
      @(posedge clk); #1;
    end
    p1_req = 1'b0;

    //          port we addr          size   uns wdata         rdata         err mask     mem_wdata
    tbl.push_back('{0, 1, 32'h10,   2'b10, 0, 32'hDEADBEEF, 32'h0,        0, 4'b1111, 32'hDEADBEEF});
    tbl.push_back('{0, 0, 32'h10,   2'b10, 0, 32'h0,        32'hDEADBEEF, 0, 4'b0000, 32'h0});
    tbl.push_back('{0, 1, 32'h20,   2'b10, 0, 32'h11223344, 32'h0,        0, 4'b1111, 32'h11223344});
    tbl.push_back('{0, 0, 32'h23,   2'b00, 0, 32'h0,        32'h00000011, 0, 4'b0000, 32'h0});
    tbl.push_back('{0, 1, 32'h21,   2'b00, 0, 32'hFFFFFF80, 32'h0,        0, 4'b0010, 32'h80808080});
    tbl.push_back('{0, 0, 32'h21,   2'b00, 0, 32'h0,        32'hFFFFFF80, 0, 4'b0000, 32'h0});
    tbl.push_back('{0, 0, 32'h21,   2'b00, 1, 32'h0,        32'h00000080, 0, 4'b0000, 32'h0});
    tbl.push_back('{0, 0, 32'h22,   2'b01, 0, 32'h0,        32'h00001122, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 0, 32'h20,   2'b01, 0, 32'h0,        32'hFFFF8044, 0, 4'b0000, 32'h0});
    tbl.push_back('{1, 1, 32'h26,   2'b01, 0, 32'h1234ABCD, 32'h0,        0, 4'b1100, 32'hABCDABCD});
    tbl.push_back('{1, 0, 32'h24,   2'b10, 0, 32'h0,        32'hABCD0000, 0, 4'b0000, 32'h0});
    tbl.push_back('{0, 0, 32'h02,   2'b10, 0, 32'h0,        32'h0,        1, 4'b0000, 32'h0});
    tbl.push_back('{0, 1, 32'h01,   2'b01, 0, 32'hFFFF,     32'h0,        1, 4'b0000, 32'h0});
    tbl.push_back('{1, 0, 32'h00,   2'b11, 0, 32'h0,        32'h0,        1, 4'b0000, 32'h0});
    tbl.push_back('{0, 1, 32'h1000, 2'b10, 0, 32'h12345678, 32'h0,        1, 4'b0000, 32'h0});
    tbl.push_back('{1, 0, 32'h0FFC, 2'b10, 0, 32'h0,        32'h0,        0, 4'b0000, 32'h0});
    for (int i = 0; i < tbl.size(); i++) issue(tbl[i]);

    // Store on port 0 then load of the same word on port 1 the next cycle.
    v = '{0, 1, 32'h30, 2'b10, 0, 32'h55AA1234, 32'h0, 0, 4'b1111, 32'h55AA1234};
    issue(v);
    v = '{1, 0, 32'h30, 2'b10, 0, 32'h0, 32'h55AA1234, 0, 4'b0000, 32'h0};
    issue(v);

    // Reset arriving the cycle after a port-1 grant drops that response.
    drive(1, 1, 0, 32'h10, 2'b10, 0, 32'h0);
    @(negedge clk);
    check("midrst_gnt", p1_gnt, 1);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("midrst_rvalid", p1_rvalid, 0);
      check("midrst_no_gnt", p1_gnt, 0);
      check("midrst_rdata", p1_rdata, 0);
      @(posedge clk); #1;
    end
    rst = 1'b0;
    @(negedge clk);
    check("postrst_gnt", p1_gnt, 1);
    if (p1_gnt) push(1, 32'hDEADBEEF, 0);
    @(posedge clk); #1 drive(1, 0, 0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
